// File: rtl/mem_xfer_sequencer_pkg.sv
// Shared types and width helpers for the memory-transfer sequencer.
package mem_xfer_pkg;

   // Sequencer phases: wait for start, load MemoryA, sweep into MemoryB, report.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      XFER = 2'd2,
      DONE = 2'd3
   } xfer_state_t;

   localparam int AW_A_DEF = 3;

   // MemoryB holds one result per MemoryA word pair, so it is one address bit narrower.
   function automatic int addr_b_width(input int aw_a);
      return aw_a - 1;
   endfunction

endpackage

// File: rtl/mem_xfer_sequencer_if.sv
// Control/handshake bundle between the sequencer and the transfer datapath.
interface mem_xfer_sequencer_if
   import mem_xfer_pkg::*;
#(
   parameter int AW_A = AW_A_DEF
) ();
   localparam int AW_B = addr_b_width(AW_A);

   logic            start;
   logic            abort;
   logic            in_valid;
   logic            in_ready;
   logic            WEA;
   logic            WEB;
   logic [AW_A-1:0] AddrA;
   logic [AW_B-1:0] AddrB;
   logic            busy;
   logic            done;

   // Sequencer side: owns both address buses and write enables.
   modport master (
      input  start, abort, in_valid,
      output in_ready, WEA, WEB, AddrA, AddrB, busy, done
   );

   // Environment side: issues commands and source data valid.
   modport slave (
      output start, abort, in_valid,
      input  in_ready, WEA, WEB, AddrA, AddrB, busy, done
   );
endinterface

// File: rtl/mem_xfer_sequencer_xfer_addr_counter.sv
// Up-counter with clear priority that saturates at all-ones; terminal flag marks the last address.
module xfer_addr_counter #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst_i,
   input  logic         clear_i,
   input  logic         incr_i,
   output logic [W-1:0] count_o,
   output logic         term_o
);
   logic [W-1:0] cnt_q, cnt_d;

   assign term_o  = (cnt_q == {W{1'b1}});
   assign count_o = cnt_q;

   // Next count: clear wins, increment never steps past the terminal value.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i)
         cnt_d = '0;
      else if (incr_i && !term_o)
         cnt_d = cnt_q + W'(1);
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst_i)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end
endmodule

// File: rtl/mem_xfer_sequencer.sv
// Fill-then-transfer sequencer: loads MemoryA from a valid/ready source, then sweeps
// it so each word pair produces one MemoryB write.
module mem_xfer_sequencer
   import mem_xfer_pkg::*;
#(
   parameter int AW_A = AW_A_DEF
) (
   input  logic clk,
   input  logic Reset,
   mem_xfer_sequencer_if.master bus
);
   xfer_state_t     state_q, state_d;
   logic            cnt_clr, cnt_inc, cnt_term;
   logic [AW_A-1:0] addr_a;
   logic            accept;
   logic            kill;

   // Abort and reset both suppress memory writes in the cycle they are seen.
   assign kill   = bus.abort | Reset;
   assign accept = (state_q == FILL) & bus.in_valid;

   xfer_addr_counter #(.W(AW_A)) u_addr_a (
      .clk     (clk),
      .rst_i   (Reset),
      .clear_i (cnt_clr),
      .incr_i  (cnt_inc),
      .count_o (addr_a),
      .term_o  (cnt_term)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (Reset)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // Next state and counter control; abort overrides every transition.
   always_comb begin
      state_d = state_q;
      cnt_clr = 1'b0;
      cnt_inc = 1'b0;
      case (state_q)
         IDLE: if (bus.start) state_d = FILL;
         FILL: begin
            if (accept) begin
               if (cnt_term) begin
                  state_d = XFER;
                  cnt_clr = 1'b1;
               end else begin
                  cnt_inc = 1'b1;
               end
            end
         end
         XFER: begin
            if (cnt_term) begin
               state_d = DONE;
               cnt_clr = 1'b1;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (bus.abort) begin
         state_d = IDLE;
         cnt_clr = 1'b1;
      end
   end

   // Outputs decode from state/counter; only WEA follows the source handshake directly.
   // B[k] is written while AddrA = 2k+1, when the delay register holds A[2k].
   assign bus.in_ready = (state_q == FILL);
   assign bus.WEA      = accept & ~kill;
   assign bus.WEB      = (state_q == XFER) & addr_a[0] & ~kill;
   assign bus.AddrA    = addr_a;
   assign bus.AddrB    = addr_a[AW_A-1:1];
   assign bus.busy     = (state_q != IDLE);
   assign bus.done     = (state_q == DONE);
endmodule
